// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling,
// EX-stage operand forwarding and a saturating bubble counter.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_alu_sel,
    input  logic        id_a_sel,
    input  logic        id_b_sel,
    input  logic        id_reg_we,
    input  logic        id_mem_rd,
    input  logic        id_mem_wr,
    input  logic        id_is_branch,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_we,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_we,
    input  logic [31:0] wb_result,
    input  logic        flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic [3:0]  ex_alu_sel,
    output logic [31:0] ex_dataA,
    output logic [31:0] ex_dataB,
    output logic [31:0] ex_store_data,
    output logic        ex_reg_we,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_is_branch,
    output logic [15:0] bubble_count
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rs1_data_q, rs1_data_d;
    logic [31:0] rs2_data_q, rs2_data_d;
    logic [31:0] imm_q, imm_d;
    logic [3:0]  alu_sel_q, alu_sel_d;
    logic        a_sel_q, a_sel_d;
    logic        b_sel_q, b_sel_d;
    logic        reg_we_q, reg_we_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        is_branch_q, is_branch_d;
    logic [15:0] bubble_count_q, bubble_count_d;

    logic        hazard;
    logic        bubble;
    logic [31:0] fa;
    logic [31:0] fb;

    // Store data comes from rs2 even when b_sel picks the immediate, so a
    // store's rs2 also counts as a use.
    always_comb begin
        hazard = valid_q & mem_rd_q & (rd_q != 5'd0) & id_valid &
                 (((~id_a_sel) & (id_rs1 == rd_q)) |
                  (((~id_b_sel) | id_mem_wr) & (id_rs2 == rd_q)));
        bubble   = hazard | flush;
        id_stall = hazard & ~flush & rst_n;
    end

    always_comb begin
        valid_d     = id_valid;
        pc_d        = id_pc;
        rs1_d       = id_rs1;
        rs2_d       = id_rs2;
        rd_d        = id_rd;
        rs1_data_d  = id_rs1_data;
        rs2_data_d  = id_rs2_data;
        imm_d       = id_imm;
        alu_sel_d   = id_alu_sel;
        a_sel_d     = id_a_sel;
        b_sel_d     = id_b_sel;
        reg_we_d    = id_reg_we & id_valid;
        mem_rd_d    = id_mem_rd & id_valid;
        mem_wr_d    = id_mem_wr & id_valid;
        is_branch_d = id_is_branch & id_valid;
        if (bubble) begin
            valid_d     = 1'b0;
            pc_d        = 32'd0;
            rs1_d       = 5'd0;
            rs2_d       = 5'd0;
            rd_d        = 5'd0;
            rs1_data_d  = 32'd0;
            rs2_data_d  = 32'd0;
            imm_d       = 32'd0;
            alu_sel_d   = 4'd0;
            a_sel_d     = 1'b0;
            b_sel_d     = 1'b0;
            reg_we_d    = 1'b0;
            mem_rd_d    = 1'b0;
            mem_wr_d    = 1'b0;
            is_branch_d = 1'b0;
        end
        bubble_count_d = bubble_count_q;
        if (bubble && (bubble_count_q != 16'hFFFF)) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q        <= 1'b0;
            pc_q           <= 32'd0;
            rs1_q          <= 5'd0;
            rs2_q          <= 5'd0;
            rd_q           <= 5'd0;
            rs1_data_q     <= 32'd0;
            rs2_data_q     <= 32'd0;
            imm_q          <= 32'd0;
            alu_sel_q      <= 4'd0;
            a_sel_q        <= 1'b0;
            b_sel_q        <= 1'b0;
            reg_we_q       <= 1'b0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            is_branch_q    <= 1'b0;
            bubble_count_q <= 16'd0;
        end else begin
            valid_q        <= valid_d;
            pc_q           <= pc_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            imm_q          <= imm_d;
            alu_sel_q      <= alu_sel_d;
            a_sel_q        <= a_sel_d;
            b_sel_q        <= b_sel_d;
            reg_we_q       <= reg_we_d;
            mem_rd_q       <= mem_rd_d;
            mem_wr_q       <= mem_wr_d;
            is_branch_q    <= is_branch_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        fa = rs1_data_q;
        if (mem_reg_we && (mem_rd != 5'd0) && (mem_rd == rs1_q)) begin
            fa = mem_result;
        end else if (wb_reg_we && (wb_rd != 5'd0) && (wb_rd == rs1_q)) begin
            fa = wb_result;
        end
        fb = rs2_data_q;
        if (mem_reg_we && (mem_rd != 5'd0) && (mem_rd == rs2_q)) begin
            fb = mem_result;
        end else if (wb_reg_we && (wb_rd != 5'd0) && (wb_rd == rs2_q)) begin
            fb = wb_result;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rd         = rd_q;
    assign ex_alu_sel    = alu_sel_q;
    assign ex_dataA      = a_sel_q ? pc_q : fa;
    assign ex_dataB      = b_sel_q ? imm_q : fb;
    assign ex_store_data = fb;
    assign ex_reg_we     = reg_we_q;
    assign ex_mem_rd     = mem_rd_q;
    assign ex_mem_wr     = mem_wr_q;
    assign ex_is_branch  = is_branch_q;
    assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: behavioural model checked every cycle, plus
// directed scenarios with literal expectations and a saturation run.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_sel;
    logic        id_a_sel, id_b_sel, id_reg_we, id_mem_rd, id_mem_wr, id_is_branch;
    logic [4:0]  mem_rd;
    logic        mem_reg_we;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_we;
    logic [31:0] wb_result;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_sel;
    logic [31:0] ex_dataA, ex_dataB, ex_store_data;
    logic        ex_reg_we, ex_mem_rd, ex_mem_wr, ex_is_branch;
    logic [15:0] bubble_count;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_sel(id_alu_sel), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .id_is_branch(id_is_branch),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_result(wb_result),
        .flush(flush), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_alu_sel(ex_alu_sel),
        .ex_dataA(ex_dataA), .ex_dataB(ex_dataB), .ex_store_data(ex_store_data),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_is_branch(ex_is_branch), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: the instruction currently sitting in EX, as plain fields.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0]  alu;
        logic        asel, bsel, we, mrd, mwr, br;
    } ex_t;

    ex_t m;
    int  m_cnt;

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 0) return d;
        if (mem_reg_we && mem_rd == r) return mem_result;
        if (wb_reg_we && wb_rd == r) return wb_result;
        return d;
    endfunction

    function automatic bit uses_reg(input logic [4:0] r);
        bit use1, use2;
        use1 = !id_a_sel && id_rs1 == r;
        use2 = (!id_b_sel || id_mem_wr) && id_rs2 == r;
        return use1 || use2;
    endfunction

    function automatic bit mdl_hazard();
        return m.valid && m.mrd && m.rd != 0 && id_valid && uses_reg(m.rd);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m = '0;
            m_cnt = 0;
        end else if (flush || mdl_hazard()) begin
            m = '0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m.valid = id_valid;   m.pc = id_pc;
            m.rs1 = id_rs1;       m.rs2 = id_rs2;       m.rd = id_rd;
            m.d1 = id_rs1_data;   m.d2 = id_rs2_data;   m.imm = id_imm;
            m.alu = id_alu_sel;   m.asel = id_a_sel;    m.bsel = id_b_sel;
            m.we = id_reg_we && id_valid;  m.mrd = id_mem_rd && id_valid;
            m.mwr = id_mem_wr && id_valid; m.br = id_is_branch && id_valid;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("m_stall", {31'd0, id_stall}, {31'd0, rst_n && !flush && mdl_hazard()});
            check("m_valid", {31'd0, ex_valid}, {31'd0, m.valid});
            check("m_pc", ex_pc, m.pc);
            check("m_rd", {27'd0, ex_rd}, {27'd0, m.rd});
            check("m_alu", {28'd0, ex_alu_sel}, {28'd0, m.alu});
            check("m_dataA", ex_dataA, m.asel ? m.pc : fwd(m.rs1, m.d1));
            check("m_dataB", ex_dataB, m.bsel ? m.imm : fwd(m.rs2, m.d2));
            check("m_store", ex_store_data, fwd(m.rs2, m.d2));
            check("m_ctrl", {28'd0, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_is_branch},
                  {28'd0, m.we, m.mrd, m.mwr, m.br});
            check("m_bcnt", {16'd0, bubble_count}, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_sel = 0;
        id_a_sel = 0; id_b_sel = 0; id_reg_we = 0; id_mem_rd = 0; id_mem_wr = 0;
        id_is_branch = 0; mem_rd = 0; mem_reg_we = 0; mem_result = 0;
        wb_rd = 0; wb_reg_we = 0; wb_result = 0; flush = 0;
    endtask

    task automatic present_load(input logic [4:0] rd);
        idle();
        id_valid = 1; id_rd = rd; id_mem_rd = 1; id_reg_we = 1;
        id_b_sel = 1; id_rs1 = 5'd9; id_imm = 32'h8;
    endtask

    task automatic present_use(input logic [4:0] rs1);
        idle();
        id_valid = 1; id_rs1 = rs1; id_rs2 = 5'd11; id_rd = 5'd12;
        id_rs1_data = 32'h1234; id_reg_we = 1; id_pc = 32'h40;
    endtask

    task automatic randomize_inputs();
        id_valid     = ($urandom_range(0, 9) != 0);
        id_pc        = $urandom;
        id_rs1       = 5'($urandom_range(0, 7));
        id_rs2       = 5'($urandom_range(0, 7));
        id_rd        = 5'($urandom_range(0, 7));
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
        id_alu_sel   = 4'($urandom);
        id_a_sel     = 1'($urandom);
        id_b_sel     = 1'($urandom);
        id_reg_we    = 1'($urandom);
        id_mem_rd    = ($urandom_range(0, 2) == 0);
        id_mem_wr    = ($urandom_range(0, 3) == 0);
        id_is_branch = ($urandom_range(0, 4) == 0);
        mem_rd       = 5'($urandom_range(0, 7));
        mem_reg_we   = 1'($urandom);
        mem_result   = $urandom;
        wb_rd        = 5'($urandom_range(0, 7));
        wb_reg_we    = 1'($urandom);
        wb_result    = $urandom;
        flush        = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        idle();
        rst_n = 0;
        tick();
        cmp_on = 1;
        tick();
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_bcnt", {16'd0, bubble_count}, 32'd0);
        check("rst_stall", {31'd0, id_stall}, 32'd0);
        check("rst_pc", ex_pc, 32'd0);
        rst_n = 1;

        // ADD x3 = x1 + x2
        idle();
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_reg_we = 1;
        id_rs1_data = 5; id_rs2_data = 7; id_alu_sel = 4'd0;
        tick();
        check("add_valid", {31'd0, ex_valid}, 32'd1);
        check("add_dataA", ex_dataA, 32'd5);
        check("add_dataB", ex_dataB, 32'd7);
        check("add_we", {31'd0, ex_reg_we}, 32'd1);

        // Forwarding priority on rs1=3
        idle();
        id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h99; id_rd = 6;
        tick();
        mem_rd = 3; mem_reg_we = 1; mem_result = 32'h10;
        wb_rd = 3; wb_reg_we = 1; wb_result = 32'h20;
        #1 check("fwd_mem", ex_dataA, 32'h10);
        mem_reg_we = 0;
        #1 check("fwd_wb", ex_dataA, 32'h20);
        idle();
        id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h55;
        tick();
        mem_rd = 0; mem_reg_we = 1; mem_result = 32'h10;
        wb_rd = 0; wb_reg_we = 1; wb_result = 32'h20;
        #1 check("fwd_x0", ex_dataA, 32'h55);

        // Load-use stall
        present_load(5'd4);
        tick();
        present_use(5'd4);
        #1 check("lu_stall", {31'd0, id_stall}, 32'd1);
        tick();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        check("lu_bcnt", {16'd0, bubble_count}, 32'd1);
        check("lu_nostall", {31'd0, id_stall}, 32'd0);
        tick();
        check("lu_capture", {31'd0, ex_valid}, 32'd1);
        check("lu_pc", ex_pc, 32'h40);

        // Hazard and flush together
        present_load(5'd4);
        tick();
        present_use(5'd4);
        flush = 1;
        #1 check("hf_stall", {31'd0, id_stall}, 32'd0);
        tick();
        check("hf_valid", {31'd0, ex_valid}, 32'd0);
        check("hf_ctrl", {28'd0, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_is_branch}, 32'd0);
        check("hf_bcnt", {16'd0, bubble_count}, 32'd2);

        // pc/imm operand selection with forwarded store data
        idle();
        id_valid = 1; id_a_sel = 1; id_b_sel = 1; id_pc = 32'h100;
        id_imm = 32'hFFFF_FFFC; id_rs2 = 5; id_rs2_data = 32'h77; id_mem_wr = 1;
        tick();
        mem_rd = 5; mem_reg_we = 1; mem_result = 32'hABCD;
        #1;
        check("sel_dataA", ex_dataA, 32'h100);
        check("sel_dataB", ex_dataB, 32'hFFFF_FFFC);
        check("sel_store", ex_store_data, 32'hABCD);
        check("sel_mwr", {31'd0, ex_mem_wr}, 32'd1);

        // Random traffic, with occasional mid-stream resets
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1;

        // Saturation of the bubble counter
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        flush = 1;
        for (int i = 0; i < 65535; i++) tick();
        flush = 0;
        check("sat_preset", {16'd0, bubble_count}, 32'hFFFF);
        present_load(5'd7);
        tick();
        present_use(5'd7);
        #1 check("sat_stall", {31'd0, id_stall}, 32'd1);
        tick();
        check("sat_hold", {16'd0, bubble_count}, 32'hFFFF);
        rst_n = 0;
        tick();
        check("sat_reset", {16'd0, bubble_count}, 32'd0);
        rst_n = 1;
        present_use(5'd2);
        tick();
        check("post_rst_valid", {31'd0, ex_valid}, 32'd1);
        check("post_rst_pc", ex_pc, 32'h40);
        tick();

        cmp_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports id_valid in 1, id_pc in 32, id_rs1/id_rs2/id_rd in 5 each, id_rs1_data/id_rs2_data/id_imm in 32 each: decoded instruction and register-file reads.
REQ-004 SHALL have ports id_alu_sel in 4 (shared ALU opcode definitions), id_a_sel in 1 (0 rs1, 1 pc), id_b_sel in 1 (0 rs2, 1 imm), id_reg_we/id_mem_rd/id_mem_wr/id_is_branch in 1 each.
REQ-005 SHALL have ports mem_rd in 5, mem_reg_we in 1, mem_result in 32: EX/MEM forwarding source.
REQ-006 SHALL have ports wb_rd in 5, wb_reg_we in 1, wb_result in 32: MEM/WB forwarding source.
REQ-007 SHALL have port flush in 1: taken branch/jump; discard the decode instruction.
REQ-008 SHALL have port id_stall out 1: load-use hazard; decode/fetch hold.
REQ-009 SHALL have ports ex_valid out 1, ex_pc out 32, ex_rd out 5, ex_alu_sel out 4, ex_dataA/ex_dataB/ex_store_data out 32, ex_reg_we/ex_mem_rd/ex_mem_wr/ex_is_branch out 1.
REQ-010 SHALL have port bubble_count out 16: saturating count of inserted bubbles.

Function
REQ-011 Registered fields (pc, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_sel, a_sel, b_sel, control bits, valid) SHALL update every cycle; single-cycle latency, no enable other than hazard/flush rules below.
REQ-012 load-use hazard = ex_valid & ex_mem_rd & ex_rd!=0 & id_valid & ((id_a_sel==0 & id_rs1==ex_rd) | ((id_b_sel==0 | id_mem_wr) & id_rs2==ex_rd)).
REQ-013 id_stall SHALL equal hazard & ~flush, combinational.
REQ-014 On flush, next cycle SHALL be bubble: ex_valid=0, all ex_ control bits=0; flush wins over stall.
REQ-015 On stall (no flush), next cycle SHALL be bubble; decode contents are not captured and are re-presented by upstream.
REQ-016 Otherwise register captures decode fields; ex_valid<=id_valid; control bits captured ANDed with id_valid.
REQ-017 Bubble: ex_reg_we, ex_mem_rd, ex_mem_wr, ex_is_branch SHALL be 0; data fields don't-care, driven 0.
REQ-018 Forwarded rs1 (fa) combinational from registered rs1: mem_reg_we & mem_rd!=0 & mem_rd==rs1 -> mem_result; else wb_reg_we & wb_rd!=0 & wb_rd==rs1 -> wb_result; else registered rs1_data. Same rule for rs2 (fb).
REQ-019 EX/MEM source SHALL take priority over MEM/WB when both match; x0 never forwarded.
REQ-020 ex_dataA = a_sel ? ex_pc : fa; ex_dataB = b_sel ? imm : fb; ex_store_data = fb always.
REQ-021 ex_alu_sel SHALL pass registered alu_sel unchanged; no re-encoding.
REQ-022 bubble_count SHALL increment by 1 for each cycle whose next state is a bubble due to stall or flush (not id_valid=0); saturates at 16'hFFFF, no wrap.

Reset
REQ-023 rst_n=0 at rising edge SHALL clear all registers: ex_valid=0, control bits 0, pc/rd/rs/data/imm/alu_sel 0, bubble_count 0.
REQ-024 During reset, id_stall SHALL be 0 (ex_valid=0 forces no hazard next cycle).
REQ-025 Reset mid-operation SHALL discard the in-flight instruction; first cycle after rst_n=1 captures decode normally.

Verification
REQ-026 ADD rs1=1 rs2=2 rd=3, rs1_data=5, rs2_data=7, no forwarding -> next cycle ex_valid=1, ex_dataA=5, ex_dataB=7, ex_reg_we=1.
REQ-027 EX rs1=3; mem_rd=3 mem_result=0x10, wb_rd=3 wb_result=0x20, both we=1 -> ex_dataA=0x10; mem_reg_we=0 -> 0x20; rs1=0 with mem_rd=0 -> regfile value.
REQ-028 EX holds load rd=4; decode rs1=4 a_sel=0 -> id_stall=1, next cycle ex_valid=0, bubble_count=1; re-presented instruction then captured, id_stall=0.
REQ-029 Hazard and flush same cycle -> id_stall=0, next ex_valid=0, all control bits 0, bubble_count+1.
REQ-030 b_sel=1 imm=0xFFFFFFFC, a_sel=1 pc=0x100 -> ex_dataA=0x100, ex_dataB=0xFFFFFFFC, ex_store_data=forwarded rs2.
REQ-031 bubble_count preset near saturation via 65535 stalls, one more stall -> stays 0xFFFF; rst_n=0 -> 0.
